// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP responder that oversamples tck/tms/tdi/trst_n with clk.
// Provides a 5-bit IR plus IDCODE, BYPASS and a USER mailbox data register.
module jtag_tap_sampled #(
    parameter int                  IR_WIDTH      = 5,
    parameter logic [31:0]         IDCODE_VAL    = 32'h1000_0AB1,
    parameter int                  USER_DR_WIDTH = 32,
    parameter logic [IR_WIDTH-1:0] IR_IDCODE     = 5'h01,
    parameter logic [IR_WIDTH-1:0] IR_USER       = 5'h10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tck,
    input  logic                     tms,
    input  logic                     tdi,
    input  logic                     trst_n,
    output logic                     tdo,
    output logic                     tdo_en,
    input  logic [USER_DR_WIDTH-1:0] user_dr_in,
    output logic [USER_DR_WIDTH-1:0] user_dr_out,
    output logic                     user_dr_upd,
    output logic [3:0]               tap_state
);
    typedef enum logic [3:0] {
        TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
        SH_IR = 4'hA, EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;
    localparam logic [IR_WIDTH-1:0] IR_CAP = {{(IR_WIDTH-2){1'b0}}, 2'b01};
    logic tck_s1_q, tck_s2_q, tck_s3_q, tms_s1_q, tms_s2_q, tdi_s1_q, tdi_s2_q, trst_s1_q, trst_s2_q;
    tap_state_e state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
    logic [31:0] id_sr_q;
    logic [USER_DR_WIDTH-1:0] user_sr_q, user_out_q;
    logic byp_q, tdo_q, tdo_en_q, upd_q;
    logic tck_rise, tck_fall, tap_rst, sel_id, sel_user, dr_lsb, upd_fire;
    assign tck_rise = tck_s2_q & ~tck_s3_q;
    assign tck_fall = ~tck_s2_q & tck_s3_q;
    assign tap_rst  = rst | ~trst_s2_q;
    assign sel_id   = ir_q == IR_IDCODE;
    assign sel_user = ir_q == IR_USER;
    assign dr_lsb   = sel_id ? id_sr_q[0] : sel_user ? user_sr_q[0] : byp_q;
    assign upd_fire = tck_fall & (state_q == UPD_DR) & sel_user;
    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:     state_d = tms_s2_q ? TLR    : RTI;
            RTI:     state_d = tms_s2_q ? SEL_DR : RTI;
            SEL_DR:  state_d = tms_s2_q ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms_s2_q ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms_s2_q ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms_s2_q ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = tms_s2_q ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = tms_s2_q ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms_s2_q ? SEL_DR : RTI;
            SEL_IR:  state_d = tms_s2_q ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms_s2_q ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms_s2_q ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms_s2_q ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = tms_s2_q ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = tms_s2_q ? UPD_IR : SH_IR;
            default: state_d = tms_s2_q ? SEL_DR : RTI;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {tck_s1_q, tck_s2_q, tck_s3_q, tdi_s1_q, tdi_s2_q} <= '0;
            {tms_s1_q, tms_s2_q, trst_s1_q, trst_s2_q} <= '1;
        end else begin
            {tck_s3_q, tck_s2_q, tck_s1_q} <= {tck_s2_q, tck_s1_q, tck};
            {tms_s2_q, tms_s1_q} <= {tms_s1_q, tms};
            {tdi_s2_q, tdi_s1_q} <= {tdi_s1_q, tdi};
            {trst_s2_q, trst_s1_q} <= {trst_s1_q, trst_n};
        end
        if (tap_rst) begin
            state_q   <= TLR;
            ir_q      <= IR_IDCODE;
            ir_sr_q   <= '0;
            id_sr_q   <= '0;
            user_sr_q <= '0;
            byp_q     <= 1'b0;
            tdo_q     <= 1'b0;
            tdo_en_q  <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            upd_q <= upd_fire;
            if (tck_rise) begin
                state_q <= state_d;
                case (state_q)
                    CAP_IR: ir_sr_q <= IR_CAP;
                    SH_IR:  ir_sr_q <= {tdi_s2_q, ir_sr_q[IR_WIDTH-1:1]};
                    CAP_DR: if (sel_id) id_sr_q <= IDCODE_VAL;
                            else if (sel_user) user_sr_q <= user_dr_in;
                            else byp_q <= 1'b0;
                    SH_DR:  if (sel_id) id_sr_q <= {tdi_s2_q, id_sr_q[31:1]};
                            else if (sel_user) user_sr_q <= {tdi_s2_q, user_sr_q[USER_DR_WIDTH-1:1]};
                            else byp_q <= tdi_s2_q;
                    default: ;
                endcase
            end
            if (tck_fall) begin
                if (state_q == SH_IR) tdo_q <= ir_sr_q[0];
                else if (state_q == SH_DR) tdo_q <= dr_lsb;
                tdo_en_q <= (state_q == SH_IR) || (state_q == SH_DR);
                if (state_q == UPD_IR) ir_q <= ir_sr_q;
            end
            // Holding IR at IDCODE in TLR makes the first DR scan after reset read IDCODE
            if (state_q == TLR) ir_q <= IR_IDCODE;
        end
        if (rst) user_out_q <= '0;
        else if (trst_s2_q && upd_fire) user_out_q <= user_sr_q;
    end
    assign tdo         = tdo_q;
    assign tdo_en      = tdo_en_q;
    assign user_dr_out = user_out_q;
    assign user_dr_upd = upd_q;
    assign tap_state   = state_q;
endmodule

// File: tb/tb_jtag_tap_sampled.sv
// tb_jtag_tap_sampled: randomized scoreboard bench for jtag_tap_sampled.
// A behavioural TAP model queues expectations per tck rise; monitors compare asynchronously.
module tb_jtag_tap_sampled;
    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
        S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUDR = 4'h3, S_EX2DR = 4'h0, S_UPDDR = 4'h5,
        S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA, S_EX1IR = 4'h9, S_PAUIR = 4'hB,
        S_EX2IR = 4'h8, S_UPDIR = 4'hD;
    localparam logic [31:0] IDCODE = 32'h1000_0AB1;
    localparam logic [4:0] IR_ID = 5'h01, IR_USR = 5'h10;
    logic clk = 1'b0, rst = 1'b1, tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
    logic [31:0] user_dr_in = '0, user_dr_out;
    logic tdo, tdo_en, user_dr_upd;
    logic [3:0] tap_state;
    int checks = 0, errors = 0;
    typedef struct {logic [3:0] st; bit chk; logic tdo; logic en;} ent_t;
    ent_t exp_q[$];
    logic [31:0] upd_q[$];
    logic [3:0] ms = S_TLR;
    logic [4:0] mir = IR_ID;
    logic [31:0] m_user = '0;
    logic dq[$];
    logic iq[$];
    logic upd_prev = 1'b0;

    jtag_tap_sampled dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trst_n(trst_n),
        .tdo(tdo), .tdo_en(tdo_en), .user_dr_in(user_dr_in), .user_dr_out(user_dr_out),
        .user_dr_upd(user_dr_upd), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] s, input logic m);
        case (s)
            S_TLR:   return m ? S_TLR   : S_RTI;
            S_RTI:   return m ? S_SELDR : S_RTI;
            S_SELDR: return m ? S_SELIR : S_CAPDR;
            S_CAPDR: return m ? S_EX1DR : S_SHDR;
            S_SHDR:  return m ? S_EX1DR : S_SHDR;
            S_EX1DR: return m ? S_UPDDR : S_PAUDR;
            S_PAUDR: return m ? S_EX2DR : S_PAUDR;
            S_EX2DR: return m ? S_UPDDR : S_SHDR;
            S_UPDDR: return m ? S_SELDR : S_RTI;
            S_SELIR: return m ? S_TLR   : S_CAPIR;
            S_CAPIR: return m ? S_EX1IR : S_SHIR;
            S_SHIR:  return m ? S_EX1IR : S_SHIR;
            S_EX1IR: return m ? S_UPDIR : S_PAUIR;
            S_PAUIR: return m ? S_EX2IR : S_PAUIR;
            S_EX2IR: return m ? S_UPDIR : S_SHIR;
            default: return m ? S_SELDR : S_RTI;
        endcase
    endfunction

    // Registers are modelled as bit queues: front is the bit presented on tdo
    function automatic logic [31:0] pack(input logic q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) if (i < 32) v[i] = q[i];
        return v;
    endfunction

    task automatic tck_cycle(input logic m, input logic d);
        ent_t e;
        logic [31:0] cap, t;
        int w;
        tms = m;
        tdi = d;
        e.chk = (ms == S_SHDR) || (ms == S_SHIR);
        e.en  = e.chk;
        e.tdo = e.chk ? (ms == S_SHIR ? iq[0] : dq[0]) : 1'b0;
        case (ms)
            S_CAPDR: begin
                cap = mir == IR_ID ? IDCODE : mir == IR_USR ? user_dr_in : 32'h0;
                w = (mir == IR_ID || mir == IR_USR) ? 32 : 1;
                dq.delete();
                for (int i = 0; i < w; i++) dq.push_back(cap[i]);
            end
            S_SHDR: begin void'(dq.pop_front()); dq.push_back(d); end
            S_CAPIR: iq = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            S_SHIR: begin void'(iq.pop_front()); iq.push_back(d); end
            default: ;
        endcase
        ms = nxt(ms, m);
        e.st = ms;
        if (ms == S_UPDIR) begin t = pack(iq); mir = t[4:0]; end
        if (ms == S_UPDDR && mir == IR_USR) begin m_user = pack(dq); upd_q.push_back(m_user); end
        if (ms == S_TLR) mir = IR_ID;
        repeat (2) @(negedge clk);
        exp_q.push_back(e);
        tck = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic scan(input bit is_ir, input logic [31:0] v, input int n);
        tck_cycle(1'b1, 1'b0);
        if (is_ir) tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < n; i++) tck_cycle(i == n - 1, v[i]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    initial begin : tck_monitor
        ent_t e;
        forever begin
            @(posedge tck);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tck_rise no expectation queued");
            end else begin
                e = exp_q.pop_front();
                check("tdo_en", tdo_en, e.en);
                if (e.chk) check("tdo", tdo, e.tdo);
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("tap_state", tap_state, e.st);
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] x;
        if (user_dr_upd) begin
            if (upd_prev) begin
                checks++;
                errors++;
                $display("FAIL user_dr_upd pulse wider than 1 clk");
            end else if (upd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL user_dr_upd unexpected got %h", user_dr_out);
            end else begin
                x = upd_q.pop_front();
                check("user_dr_out_at_upd", user_dr_out, x);
            end
        end
        upd_prev = user_dr_upd;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", tap_state, S_TLR);
        check("rst_tdo", tdo, 0);
        check("rst_tdo_en", tdo_en, 0);
        check("rst_upd", user_dr_upd, 0);
        check("rst_user_out", user_dr_out, 0);
        tck_cycle(1'b0, 1'b0);
        scan(1'b0, $urandom(), 32);
        scan(1'b1, 32'h1F, 5);
        scan(1'b0, 32'hA5, 8);
        scan(1'b1, 32'h10, 5);
        user_dr_in = 32'hDEAD_BEEF;
        scan(1'b0, 32'h1234_5678, 32);
        check("user_dr_out_hold", user_dr_out, m_user);
        scan(1'b1, 32'h01, 5);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin r = $urandom(); tck_cycle(1'b0, r[0]); end
        repeat (5) tck_cycle(1'b1, 1'b0);
        check("abort_state", tap_state, S_TLR);
        tck_cycle(1'b0, 1'b0);
        scan(1'b0, $urandom(), 32);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b1);
        tck_cycle(1'b0, 1'b1);
        trst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("trst_state", tap_state, S_TLR);
        @(negedge clk);
        trst_n = 1'b1;
        ms = S_TLR;
        mir = IR_ID;
        repeat (4) @(negedge clk);
        check("trst_user_out", user_dr_out, m_user);
        check("trst_tdo_en", tdo_en, 0);
        tms = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back('{S_TLR, 1'b0, 1'b0, 1'b0});
        tck = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tck = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ms = S_TLR;
        mir = IR_ID;
        m_user = '0;
        @(negedge clk);
        check("rst_vs_rise_state", tap_state, S_TLR);
        check("rst_user_out_clr", user_dr_out, 0);
        tck_cycle(1'b0, 1'b0);
        scan(1'b1, 32'h10, 5);
        repeat (200) begin
            r = $urandom();
            user_dr_in = $urandom();
            tck_cycle(r[0], r[1]);
        end
        repeat (12) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("upd_q_drained", upd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
